rom_bus_bridge: RTL and testbench
=================================

Name: rom_bus_bridge

Overview:
- Initiator-side bridge between the picoRV32 native memory interface and a single-port, word-wide, synchronous-read memory such as the 256-word firmware ROM/RAM: port wen, 8-bit word addr, 32-bit wdata, rdata registered on clk.
- Decodes the address window and issues the memory-side read or write.
- Absorbs the one-cycle read latency.
- Emulates byte strobes with read-modify-write, because the memory has only a word-wide write enable.
- Returns mem_ready/mem_rdata to the CPU.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base of the memory window; must be aligned to 4*2^ADDR_WIDTH.
- ADDR_WIDTH, 8: memory word-address width (256 words).
- WRITE_EN, 1: 1 = writes reach memory; 0 = writes are acknowledged, dropped and flagged (ROM protection).

Ports:
- clk, input, 1: system clock, rising edge.
- resetn, input, 1: synchronous, active-low reset.
- mem_valid, input, 1: CPU request valid, held until mem_ready.
- mem_addr, input, 32: CPU byte address, stable while mem_valid.
- mem_wdata, input, 32: CPU write data.
- mem_wstrb, input, 4: byte write strobes; 0 means read.
- mem_ready, output, 1: one-cycle transaction acknowledge.
- mem_rdata, output, 32: read data, valid when mem_ready on a read.
- wr_err, output, 1: pulses with mem_ready when a write is dropped (WRITE_EN=0).
- ram_wen, output, 1: memory write enable.
- ram_addr, output, ADDR_WIDTH: memory word address.
- ram_wdata, output, 32: memory write data.
- ram_rdata, input, 32: memory read data, valid one cycle after address.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on resetn.
- Reset values: state=IDLE, mem_ready=0, mem_rdata=0, wr_err=0, merge register=0.
- ram_wen is gated by resetn: no memory write occurs in any cycle with resetn=0.
- hit = mem_valid && (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]). mem_addr[1:0] is ignored.
- ram_addr = mem_addr[ADDR_WIDTH+1:2], combinational. The memory therefore samples the address every cycle.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, ACK. T0 is the IDLE cycle in which hit=1.
- IDLE, read (wstrb=0): go to RD. In RD, ram_rdata holds the word and is captured into mem_rdata; go to ACK. mem_ready=1 in T0+2.
- IDLE, full write (wstrb=4'b1111, WRITE_EN=1): go to WR. In WR, ram_wen=1 and ram_wdata=mem_wdata for one cycle; go to ACK. mem_ready=1 in T0+2.
- IDLE, partial write (any other nonzero wstrb, WRITE_EN=1): go to RMW_RD.
  - RMW_RD: merge register gets, per byte i, mem_wdata[i] if wstrb[i], else ram_rdata[i]; go to RMW_WR.
  - RMW_WR: ram_wen=1, ram_wdata=merge register; go to ACK. mem_ready=1 in T0+3.
- Any write with WRITE_EN=0: go to WR with ram_wen forced 0. In ACK, mem_ready=1 and wr_err=1.
- ACK: mem_ready=1 for exactly one cycle, then IDLE.
- A new request may be accepted in the cycle immediately after ACK, giving back-to-back transactions with no idle cycle.
- mem_rdata holds its last read value through writes and idle periods.
- ram_wen=0 in every state except WR and RMW_WR.
- ram_wdata = merge register outside WR (don't-care when ram_wen=0).
- Out-of-window requests: bridge stays IDLE, mem_ready stays 0. External decode answers them.
- mem_valid deasserting mid-transaction is a protocol violation. The transaction still completes and is acknowledged.
- Reset mid-operation: next state is IDLE, no ack is issued, and a partial write is aborted with memory unchanged.

Decomposition:
- Package rom_bridge_pkg holds:
  - the state enum (3-bit encoding);
  - the WSTRB_FULL = 4'b1111 and WSTRB_READ = 4'b0000 constants;
  - a function word_index(addr) returning the word-address slice.
- One sub-module, rv_byte_merge: combinational per-byte mux of old word, new word and strobe. It is reusable by other RMW bridges.

Test Plan:
- Read: preload mem[5]=32'haabbccdd, read 0x14 -> mem_ready in T0+2, mem_rdata=32'haabbccdd, ram_wen never 1.
- Full write: wstrb=4'b1111, wdata=32'h12345678, addr 0x0C -> ram_wen=1 only in T0+1 with ram_addr=3, ready T0+2; readback returns 32'h12345678.
- Partial write: mem[5]=32'haabbccdd, wstrb=4'b0010, wdata=32'h0000ee00 -> ready T0+3, mem[5]=32'haabbeedd.
- WRITE_EN=0: write 32'hffffffff to word 2 -> ready T0+2, wr_err=1 in that cycle, mem[2] unchanged, ram_wen never 1.
- Out-of-window (addr=BASE+0x400) held 10 cycles -> mem_ready stays 0. Back-to-back reads of words 1 and 2 -> acks 3 cycles apart with correct data.
- resetn=0 during RMW_RD -> no ram_wen, no mem_ready, state IDLE, memory word unchanged.

Source files
------------

// File: rtl/rom_bridge_pkg.sv
// Shared types and helpers for the picoRV32-to-word-memory bridge.
// The state enum, strobe constants and address slicing live here for reuse.
package rom_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_ACK    = 3'd5
    } state_t;

    localparam logic [3:0] WSTRB_FULL = 4'b1111;
    localparam logic [3:0] WSTRB_READ = 4'b0000;

    // Byte address to word address; callers truncate to their memory depth.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

endpackage

// File: rtl/rv_byte_merge.sv
// Per-byte select between an existing word and new write data under a strobe.
// Purely combinational so any read-modify-write bridge can drop it in.
module rv_byte_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  strb_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (strb_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/rom_bus_bridge.sv
// picoRV32 native bus to single-port synchronous word memory, with read
// latency absorption, byte-strobe emulation by read-modify-write and ROM guard.
module rom_bus_bridge
    import rom_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 8,
    parameter bit          WRITE_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  wr_err,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    state_t      state_q;
    logic        mem_ready_q;
    logic        wr_err_q;
    logic [31:0] mem_rdata_q;
    logic [31:0] merge_q;
    logic [31:0] merge_d;
    logic        hit;

    assign hit = mem_valid &&
                 (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // The memory samples the address every cycle; the CPU holds it stable.
    assign ram_addr = ADDR_WIDTH'(word_index(mem_addr));

    rv_byte_merge u_merge (
        .old_i    (ram_rdata),
        .new_i    (mem_wdata),
        .strb_i   (mem_wstrb),
        .merged_o (merge_d)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mem_ready_q <= 1'b0;
            wr_err_q    <= 1'b0;
            mem_rdata_q <= '0;
            merge_q     <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            wr_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        if (mem_wstrb == WSTRB_READ)
                            state_q <= ST_RD;
                        else if (mem_wstrb == WSTRB_FULL || !WRITE_EN)
                            state_q <= ST_WR;
                        else
                            state_q <= ST_RMW_RD;
                    end
                end
                ST_RD: begin
                    mem_rdata_q <= ram_rdata;
                    mem_ready_q <= 1'b1;
                    state_q     <= ST_ACK;
                end
                ST_WR: begin
                    mem_ready_q <= 1'b1;
                    wr_err_q    <= !WRITE_EN;
                    state_q     <= ST_ACK;
                end
                ST_RMW_RD: begin
                    merge_q <= merge_d;
                    state_q <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    mem_ready_q <= 1'b1;
                    state_q     <= ST_ACK;
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Gated by resetn so no write can slip out while reset is being applied.
    assign ram_wen = resetn &&
                     (((state_q == ST_WR) && WRITE_EN) || (state_q == ST_RMW_WR));

    assign ram_wdata = (state_q == ST_WR) ? mem_wdata : merge_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_rom_bus_bridge.sv
// Bench for rom_bus_bridge: a writable instance and a ROM-protected instance,
// each with its own synchronous-read memory model.
module tb_rom_bus_bridge;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        mem_ready_a, wr_err_a, ram_wen_a;
    logic [31:0] mem_rdata_a, ram_wdata_a, ram_rdata_a;
    logic [7:0]  ram_addr_a;
    logic        mem_ready_b, wr_err_b, ram_wen_b;
    logic [31:0] mem_rdata_b, ram_wdata_b, ram_rdata_b;
    logic [7:0]  ram_addr_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        pl_we;
    logic [7:0]  pl_idx;
    logic [31:0] pl_dat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rom_bus_bridge #(.BASE_ADDR(32'h0), .ADDR_WIDTH(8), .WRITE_EN(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready_a),
        .mem_rdata(mem_rdata_a), .wr_err(wr_err_a), .ram_wen(ram_wen_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
    );

    rom_bus_bridge #(.BASE_ADDR(32'h0), .ADDR_WIDTH(8), .WRITE_EN(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready_b),
        .mem_rdata(mem_rdata_b), .wr_err(wr_err_b), .ram_wen(ram_wen_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wen_a) mem_a[ram_addr_a] <= ram_wdata_a;
        else if (pl_we) mem_a[pl_idx] <= pl_dat;
        if (ram_wen_b) mem_b[ram_addr_b] <= ram_wdata_b;
        else if (pl_we) mem_b[pl_idx] <= pl_dat;
        ram_rdata_a <= mem_a[ram_addr_a];
        ram_rdata_b <= mem_b[ram_addr_b];
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lat;
        logic [31:0] rdata;
        int          wcnt;
        int          wcyc;
        logic [7:0]  waddr;
        int          widx;
        logic [31:0] wmem;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
        pl_we = 1'b1; pl_idx = idx; pl_dat = dat;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Called 1 time unit after a rising edge with the bridge idle; returns there.
    task automatic run_txn(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, output int lat, output logic [31:0] rd,
                           output int wcnt, output int wcyc, output logic [7:0] waddr,
                           output logic werr, output int ackc);
        mem_addr = a; mem_wdata = wd; mem_wstrb = st; mem_valid = 1'b1;
        lat = -1; rd = '0; wcnt = 0; wcyc = -1; waddr = '0; werr = 1'b0; ackc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel ? ram_wen_b : ram_wen_a) begin
                wcnt++; wcyc = k; waddr = sel ? ram_addr_b : ram_addr_a;
            end
            if (sel ? mem_ready_b : mem_ready_a) begin
                lat = k; ackc = cyc;
                rd = sel ? mem_rdata_b : mem_rdata_a;
                werr = sel ? wr_err_b : wr_err_a;
                break;
            end
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    int          lat, wcnt, wcyc, ackc, ackc2, rdy_cnt, wen_cnt;
    logic [31:0] rd, rd2;
    logic [7:0]  waddr;
    logic        werr;

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        pl_we = 1'b0; pl_idx = '0; pl_dat = '0;

        vecs[0] = '{32'h14, 32'h0,        4'b0000, 2, 32'haabbccdd, 0, -1, 8'd0, 5, 32'haabbccdd};
        vecs[1] = '{32'h0C, 32'h12345678, 4'b1111, 2, 32'haabbccdd, 1,  1, 8'd3, 3, 32'h12345678};
        vecs[2] = '{32'h0C, 32'h0,        4'b0000, 2, 32'h12345678, 0, -1, 8'd0, 3, 32'h12345678};
        vecs[3] = '{32'h14, 32'h0000ee00, 4'b0010, 3, 32'h12345678, 1,  2, 8'd5, 5, 32'haabbeedd};
        vecs[4] = '{32'h17, 32'h99000077, 4'b1001, 3, 32'h12345678, 1,  2, 8'd5, 5, 32'h99bbee77};
        vecs[5] = '{32'h16, 32'h0,        4'b0000, 2, 32'h99bbee77, 0, -1, 8'd0, 5, 32'h99bbee77};

        // Reset phase: preload memories while the bridges are held in reset.
        @(posedge clk); #1;
        preload(8'd1, 32'h11111111);
        preload(8'd2, 32'h22222222);
        preload(8'd3, 32'h00000000);
        preload(8'd5, 32'haabbccdd);
        @(negedge clk);
        chk("reset_ready", {31'd0, mem_ready_a}, 32'd0);
        chk("reset_rdata", mem_rdata_a, 32'd0);
        chk("reset_wr_err", {31'd0, wr_err_a}, 32'd0);
        chk("reset_wen", {31'd0, ram_wen_a}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_txn(1'b0, vecs[v].addr, vecs[v].wdata, vecs[v].strb,
                    lat, rd, wcnt, wcyc, waddr, werr, ackc);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
            chk($sformatf("v%0d_wen_count", v), wcnt, vecs[v].wcnt);
            chk($sformatf("v%0d_wen_cycle", v), wcyc, vecs[v].wcyc);
            chk($sformatf("v%0d_wen_addr", v), {24'd0, waddr}, {24'd0, vecs[v].waddr});
            chk($sformatf("v%0d_wr_err", v), {31'd0, werr}, 32'd0);
            chk($sformatf("v%0d_mem", v), mem_a[vecs[v].widx], vecs[v].wmem);
        end

        // Out-of-window request held for 10 cycles.
        mem_addr = 32'h400; mem_wstrb = 4'b0000; mem_valid = 1'b1;
        rdy_cnt = 0; wen_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_ready_a) rdy_cnt++;
            if (ram_wen_a) wen_cnt++;
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        chk("oow_ready", rdy_cnt, 0);
        chk("oow_wen", wen_cnt, 0);

        // Back-to-back reads with no idle cycle between them.
        run_txn(1'b0, 32'h04, 32'h0, 4'b0000, lat, rd, wcnt, wcyc, waddr, werr, ackc);
        run_txn(1'b0, 32'h08, 32'h0, 4'b0000, lat, rd2, wcnt, wcyc, waddr, werr, ackc2);
        chk("b2b_rdata1", rd, 32'h11111111);
        chk("b2b_rdata2", rd2, 32'h22222222);
        chk("b2b_gap", ackc2 - ackc, 3);

        // ROM-protected instance drops the write and flags it.
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        run_txn(1'b1, 32'h08, 32'hffffffff, 4'b1111, lat, rd, wcnt, wcyc, waddr, werr, ackc);
        chk("ro_latency", lat, 2);
        chk("ro_wr_err", {31'd0, werr}, 32'd1);
        chk("ro_wen_count", wcnt, 0);
        chk("ro_mem", mem_b[2], 32'h22222222);
        @(negedge clk);
        chk("ro_wr_err_pulse", {31'd0, wr_err_b}, 32'd0);
        @(posedge clk); #1;

        // Reset arriving in the WR cycle of a full write.
        mem_addr = 32'h04; mem_wdata = 32'hdeadbeef; mem_wstrb = 4'b1111; mem_valid = 1'b1;
        rdy_cnt = 0; wen_cnt = 0;
        @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        if (ram_wen_a) wen_cnt++;
        if (mem_ready_a) rdy_cnt++;
        @(posedge clk); #1;
        resetn = 1'b1; mem_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ram_wen_a) wen_cnt++;
            if (mem_ready_a) rdy_cnt++;
        end
        @(posedge clk); #1;
        chk("rst_wr_wen", wen_cnt, 0);
        chk("rst_wr_ready", rdy_cnt, 0);
        chk("rst_wr_mem", mem_a[1], 32'h11111111);

        // Reset arriving in RMW_RD of a partial write.
        mem_addr = 32'h14; mem_wdata = 32'h000000ff; mem_wstrb = 4'b0001; mem_valid = 1'b1;
        rdy_cnt = 0; wen_cnt = 0;
        @(negedge clk);
        if (ram_wen_a) wen_cnt++;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        if (ram_wen_a) wen_cnt++;
        if (mem_ready_a) rdy_cnt++;
        @(posedge clk); #1;
        resetn = 1'b1; mem_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ram_wen_a) wen_cnt++;
            if (mem_ready_a) rdy_cnt++;
        end
        @(posedge clk); #1;
        chk("rst_rmw_wen", wen_cnt, 0);
        chk("rst_rmw_ready", rdy_cnt, 0);
        chk("rst_rmw_mem", mem_a[5], 32'h99bbee77);

        // The bridge must be back in IDLE and serve a normal read.
        run_txn(1'b0, 32'h14, 32'h0, 4'b0000, lat, rd, wcnt, wcyc, waddr, werr, ackc);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_rdata", rd, 32'h99bbee77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
